// File: rtl/serdes_link_arbiter.sv
// serdes_link_arbiter
//   Round-robin arbiter that shares one serializer lane between NUM_REQ byte
//   requesters. Each accepted byte is sent as a two-byte frame: a header
//   {4'hA, 2'b00, id}, then the payload byte. Every byte occupies BYTE_CYCLES
//   clocks. GAP_CYCLES idle clocks follow each frame.
//
// Ports
//   clk            in   clock, rising edge
//   reset          in   synchronous, active-high reset
//   req_valid_i    in   [NUM_REQ-1:0]    requester i has a byte pending
//   req_data_i     in   [8*NUM_REQ-1:0]  byte of requester i at [8i+7:8i]
//   req_ready_o    out  [NUM_REQ-1:0]    one-hot accept, only asserted in IDLE
//   ser_data_o     out  [7:0]            parallel byte to the serializer
//   ser_load_o     out                   pulse on the first clock of a byte slot
//   busy_o         out                   high whenever not IDLE
//   grant_id_o     out  [1:0]            current or last granted requester
//   frames_sent_o  out  [15:0]           completed frame count (wraps)
module serdes_link_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int BYTE_CYCLES = 8,
    parameter int GAP_CYCLES  = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_REQ-1:0]   req_valid_i,
    input  logic [8*NUM_REQ-1:0] req_data_i,
    output logic [NUM_REQ-1:0]   req_ready_o,
    output logic [7:0]           ser_data_o,
    output logic                 ser_load_o,
    output logic                 busy_o,
    output logic [1:0]           grant_id_o,
    output logic [15:0]          frames_sent_o
);

    localparam int IDX_W   = (NUM_REQ > 2) ? 2 : 1;
    localparam int CNT_MAX = (BYTE_CYCLES > GAP_CYCLES) ? BYTE_CYCLES : GAP_CYCLES;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_HDR  = 2'd1;
    localparam logic [1:0] S_DATA = 2'd2;
    localparam logic [1:0] S_GAP  = 2'd3;

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [7:0]       payload_q, payload_d;
    logic [7:0]       ser_data_q, ser_data_d;
    logic             ser_load_q, ser_load_d;
    logic [1:0]       grant_q, grant_d;
    logic [15:0]      frames_q, frames_d;

    logic             gnt_found;
    logic [IDX_W-1:0] gnt_idx;
    logic [IDX_W-1:0] cand;
    logic [7:0]       sel_data;

    // Search from ptr+1 upward. Walking the offsets from farthest to nearest
    // lets the nearest valid requester overwrite earlier hits.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        cand      = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            cand = IDX_W'((int'(ptr_q) + k) % NUM_REQ);
            if (req_valid_i[cand]) begin
                gnt_found = 1'b1;
                gnt_idx   = cand;
            end
        end
    end

    always_comb begin
        sel_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt_idx == IDX_W'(i)) sel_data = req_data_i[8*i +: 8];
        end
    end

    assign req_ready_o = (state_q == S_IDLE && gnt_found) ? (NUM_REQ'(1) << gnt_idx) : '0;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        ptr_d      = ptr_q;
        payload_d  = payload_q;
        ser_data_d = ser_data_q;
        ser_load_d = 1'b0;
        grant_d    = grant_q;
        frames_d   = frames_q;
        case (state_q)
            S_IDLE: begin
                if (gnt_found) begin
                    payload_d  = sel_data;
                    grant_d    = 2'(gnt_idx);
                    ptr_d      = gnt_idx;
                    // Header is loaded on the accept edge so it is on the bus
                    // together with the first ser_load pulse.
                    ser_data_d = {4'hA, 2'b00, 2'(gnt_idx)};
                    ser_load_d = 1'b1;
                    cnt_d      = '0;
                    state_d    = S_HDR;
                end
            end
            S_HDR: begin
                if (cnt_q == CNT_W'(BYTE_CYCLES - 1)) begin
                    cnt_d      = '0;
                    ser_data_d = payload_q;
                    ser_load_d = 1'b1;
                    state_d    = S_DATA;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_DATA: begin
                if (cnt_q == CNT_W'(BYTE_CYCLES - 1)) begin
                    cnt_d    = '0;
                    frames_d = frames_q + 16'd1;
                    state_d  = (GAP_CYCLES == 0) ? S_IDLE : S_GAP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                if (cnt_q == CNT_W'(GAP_CYCLES - 1)) begin
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            ptr_q      <= IDX_W'(NUM_REQ - 1);  // next search starts at 0
            payload_q  <= '0;
            ser_data_q <= '0;
            ser_load_q <= 1'b0;
            grant_q    <= '0;
            frames_q   <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            ptr_q      <= ptr_d;
            payload_q  <= payload_d;
            ser_data_q <= ser_data_d;
            ser_load_q <= ser_load_d;
            grant_q    <= grant_d;
            frames_q   <= frames_d;
        end
    end

    assign ser_data_o    = ser_data_q;
    assign ser_load_o    = ser_load_q;
    assign busy_o        = (state_q != S_IDLE);
    assign grant_id_o    = grant_q;
    assign frames_sent_o = frames_q;

endmodule
